// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Functional units offer one completed result each per cycle; one winner per
// cycle is registered onto the CDB. Results carrying ROB tag 0 (the reserved
// "no producer" tag) are accepted and silently dropped, in parallel with the
// normal grant, and never move the round-robin pointer.

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

// Per-requester qualification: eligible for the bus, or a zero-tag drop.
module cdb_arbiter_lane #(
  parameter int ROB_W = 6
) (
  input  logic             valid,
  input  logic [ROB_W-1:0] rob,
  output logic             elig,
  output logic             drop
);
  assign elig = valid && (rob != '0);
  assign drop = valid && (rob == '0);
endmodule

module cdb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ROB_W  = `ROB_ENTRY_WIDTH,
  parameter int DATA_W = 32,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ROB_W-1:0]    req_rob,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [ROB_W-1:0]          cdb_rob,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } cdb_pkt_t;

  // Flat request buses viewed as per-lane packed arrays.
  logic [N_REQ-1:0][ROB_W-1:0]  rob_v;
  logic [N_REQ-1:0][DATA_W-1:0] data_v;
  assign rob_v  = req_rob;
  assign data_v = req_data;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] drop;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    cdb_arbiter_lane #(.ROB_W(ROB_W)) u_lane (
      .valid (req_valid[i]),
      .rob   (rob_v[i]),
      .elig  (elig[i]),
      .drop  (drop[i])
    );
  end

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_found;
  cdb_pkt_t         cdb_q;

  // Rotating priority scan: first eligible requester starting at ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(idx);
      end
    end
  end

  // Handshake: winner plus all zero-tag drops; nothing taken in flush/reset.
  always_comb begin
    req_ready = '0;
    if (!rst && !flush) begin
      req_ready = drop;
      if (gnt_found) req_ready[gnt_idx] = 1'b1;
    end
  end

  // Registered broadcast and pointer advance; flush only clears the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      cdb_q <= '0;
    end else if (flush) begin
      cdb_q <= '0;
    end else if (gnt_found) begin
      cdb_q.valid <= 1'b1;
      cdb_q.rob   <= rob_v[gnt_idx];
      cdb_q.data  <= data_v[gnt_idx];
      cdb_q.src   <= gnt_idx;
      ptr         <= (gnt_idx == SRC_W'(N_REQ-1)) ? '0 : gnt_idx + SRC_W'(1);
    end else begin
      cdb_q <= '0;
    end
  end

  assign cdb_valid = cdb_q.valid;
  assign cdb_rob   = cdb_q.rob;
  assign cdb_data  = cdb_q.data;
  assign cdb_src   = cdb_q.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic, checked against
// a distance-based round-robin reference model.
module tb_cdb_arbiter;
  localparam int N_REQ  = 3;
  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;
  localparam int SRC_W  = $clog2(N_REQ);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ROB_W-1:0]  req_rob;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    cdb_valid;
  logic [ROB_W-1:0]        cdb_rob;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.N_REQ(N_REQ), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_rob(req_rob), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int               m_ptr;
  logic             e_valid;
  logic [ROB_W-1:0] e_rob;
  logic [DATA_W-1:0] e_data;
  logic [SRC_W-1:0] e_src;

  function automatic logic [ROB_W-1:0] rob_of(int i);
    return req_rob[i*ROB_W +: ROB_W];
  endfunction

  // Winner = eligible requester with the smallest circular distance from ptr.
  function automatic int pick();
    int best = -1;
    int bd = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && rob_of(i) != 0) begin
        int d = (i - m_ptr + N_REQ) % N_REQ;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  function automatic logic [N_REQ-1:0] exp_ready();
    logic [N_REQ-1:0] r = '0;
    int w;
    if (rst || flush) return '0;
    for (int i = 0; i < N_REQ; i++) if (req_valid[i] && rob_of(i) == 0) r[i] = 1'b1;
    w = pick();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr <= 0; e_valid <= 0; e_rob <= 0; e_data <= 0; e_src <= 0;
    end else if (flush || pick() < 0) begin
      e_valid <= 0; e_rob <= 0; e_data <= 0; e_src <= 0;
    end else begin
      e_valid <= 1'b1;
      e_rob   <= rob_of(pick());
      e_data  <= req_data[pick()*DATA_W +: DATA_W];
      e_src   <= SRC_W'(pick());
      m_ptr   <= (pick() + 1) % N_REQ;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic v, logic [ROB_W-1:0] r, logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_rob[i*ROB_W +: ROB_W] = r;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, '0, '0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    set_req(0, 1, 5, 32'h100); set_req(1, 1, 6, 32'h101); set_req(2, 1, 7, 32'h102);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
      tick();
      checks++;
      if (cdb_valid !== 1'b0 || cdb_rob !== '0) begin
        errors++; $display("FAIL reset_cdb got v=%b rob=%0d exp v=0 rob=0", cdb_valid, cdb_rob);
      end
    end
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      #1;
      checks++;
      if (req_ready !== 3'(1 << g)) begin errors++; $display("FAIL post_reset_ready%0d got=%b exp=%b", g, req_ready, 3'(1 << g)); end
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_rob !== ROB_W'(5 + g) || cdb_src !== SRC_W'(g)) begin
        errors++; $display("FAIL post_reset_cdb%0d got v=%b rob=%0d src=%0d exp v=1 rob=%0d src=%0d",
                           g, cdb_valid, cdb_rob, cdb_src, 5 + g, g);
      end
      set_req(g, 0, 0, 0);
    end
  endtask

  task automatic test_rotation();
    set_req(0, 1, 20, 32'hA0); set_req(1, 1, 21, 32'hA1); set_req(2, 1, 22, 32'hA2);
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== SRC_W'(c % 3)) begin
        errors++; $display("FAIL rotation_src%0d got v=%b src=%0d exp v=1 src=%0d", c, cdb_valid, cdb_src, c % 3);
      end
      set_req(c % 3, 1, ROB_W'(30 + c), DATA_W'(c));
    end
    clear_reqs();
  endtask

  task automatic test_wrap();
    set_req(2, 1, 3, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 3'b100) begin errors++; $display("FAIL wrap_ready got=%b exp=100", req_ready); end
    tick();
    checks++;
    if (cdb_rob !== 6'd3 || cdb_data !== 32'hDEADBEEF || cdb_src !== 2'd2) begin
      errors++; $display("FAIL wrap_cdb got rob=%0d data=%h src=%0d exp rob=3 data=deadbeef src=2", cdb_rob, cdb_data, cdb_src);
    end
    clear_reqs();
    set_req(1, 1, 4, 32'h44);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL gap_ready got=%b exp=010", req_ready); end
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_rob !== 6'd4 || cdb_src !== 2'd1) begin
      errors++; $display("FAIL gap_cdb got v=%b rob=%0d src=%0d exp v=1 rob=4 src=1", cdb_valid, cdb_rob, cdb_src);
    end
    clear_reqs();
  endtask

  task automatic test_zero_tag();
    // ptr is 2 here; one grant to req 2 brings it back to 0.
    set_req(2, 1, 1, 32'h1);
    tick();
    clear_reqs();
    set_req(0, 1, 0, 32'hBAD); set_req(1, 1, 9, 32'h99);
    #1;
    checks++;
    if (req_ready !== 3'b011) begin errors++; $display("FAIL zero_tag_ready got=%b exp=011", req_ready); end
    tick();
    checks++;
    if (cdb_rob !== 6'd9 || cdb_src !== 2'd1) begin
      errors++; $display("FAIL zero_tag_cdb got rob=%0d src=%0d exp rob=9 src=1", cdb_rob, cdb_src);
    end
    // ptr must now be 2: with all eligible, req 2 wins.
    set_req(0, 1, 10, 0); set_req(1, 1, 11, 0); set_req(2, 1, 12, 0);
    #1;
    checks++;
    if (req_ready !== 3'b100) begin errors++; $display("FAIL zero_tag_ptr got=%b exp=100", req_ready); end
    tick();
    clear_reqs();
  endtask

  task automatic test_flush();
    // ptr is 0; one grant to req 0 makes it 1.
    set_req(0, 1, 1, 0);
    tick();
    set_req(0, 1, 2, 32'h22); set_req(1, 1, 3, 32'h33);
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL flush_ready got=%b exp=000", req_ready); end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_rob !== '0) begin
      errors++; $display("FAIL flush_cdb got v=%b rob=%0d exp v=0 rob=0", cdb_valid, cdb_rob);
    end
    flush = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL flush_resume_ready got=%b exp=010", req_ready); end
    tick();
    checks++;
    if (cdb_rob !== 6'd3 || cdb_src !== 2'd1) begin
      errors++; $display("FAIL flush_resume_cdb got rob=%0d src=%0d exp rob=3 src=1", cdb_rob, cdb_src);
    end
    clear_reqs();
  endtask

  task automatic test_idle_flush_bcast();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (cdb_valid !== 1'b0 || cdb_rob !== '0) begin
        errors++; $display("FAIL idle%0d got v=%b rob=%0d exp v=0 rob=0", c, cdb_valid, cdb_rob);
      end
    end
    set_req(0, 1, 12, 32'hC);
    tick();
    clear_reqs();
    flush = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_rob !== 6'd12) begin
      errors++; $display("FAIL bcast_before_flush got v=%b rob=%0d exp v=1 rob=12", cdb_valid, cdb_rob);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL bcast_after_flush got v=%b exp v=0", cdb_valid); end
  endtask

  task automatic test_random();
    int wait_cnt [N_REQ];
    logic [N_REQ-1:0] taken;
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 5);
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
      end
      taken = exp_ready();
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && rob_of(i) != 0 && !taken[i] && !rst && !flush) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        checks++;
        if (wait_cnt[i] >= N_REQ) begin
          errors++; $display("FAIL rand_fairness req=%0d waited=%0d limit=%0d", i, wait_cnt[i], N_REQ - 1);
        end
      end
      tick();
      checks++;
      if (cdb_valid !== e_valid || cdb_rob !== e_rob || cdb_data !== e_data || cdb_src !== e_src) begin
        errors++; $display("FAIL rand_cdb c=%0d got v=%b rob=%0d data=%h src=%0d exp v=%b rob=%0d data=%h src=%0d",
                           c, cdb_valid, cdb_rob, cdb_data, cdb_src, e_valid, e_rob, e_data, e_src);
      end
      // Requesters hold until taken; flush/reset discard pending results.
      for (int i = 0; i < N_REQ; i++) begin
        if (taken[i] || !req_valid[i] || rst || flush) begin
          logic [ROB_W-1:0] r;
          r = ($urandom_range(0, 99) < 15) ? '0 : ROB_W'($urandom_range(1, 63));
          set_req(i, ($urandom_range(0, 99) < 70), r, $urandom);
        end
      end
    end
    rst = 1'b0; flush = 1'b0;
    clear_reqs();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    req_valid = '0; req_rob = '0; req_data = '0;
    test_reset();
    test_rotation();
    test_wrap();
    test_zero_tag();
    test_flush();
    test_idle_flush_bcast();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
